// File: rtl/level_counter_pkg.sv
`default_nettype none
// ============================================================================
// level_counter_pkg : count modes and default parameters for level_counter_bank
// Rev 1.0
// ============================================================================
package level_counter_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_EDGE  = 2'b01,
    MODE_WIDTH = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_COUNT_BITS  = 8;
  localparam int DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int DEF_TICK_HZ     = 2;
  localparam int DEF_SATURATE    = 1;

endpackage
`default_nettype wire

// File: rtl/lvc_channel.sv
`default_nettype none
// ============================================================================
// lvc_channel : one input channel - synchroniser, edge detect, count/width logic
// Rev 1.0
// ============================================================================
module lvc_channel
  import level_counter_pkg::*;
#(
  parameter int COUNT_BITS = DEF_COUNT_BITS,
  parameter int SATURATE   = DEF_SATURATE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lv_in,
  input  mode_t                 mode,
  input  logic                  tick,
  input  logic                  clear,
  output logic [COUNT_BITS-1:0] count,
  output logic                  ovf,
  output logic                  done
);

  localparam logic [COUNT_BITS-1:0] ALL_ONES = '1;

  logic                  sync_a;
  logic                  lv_s;
  logic                  lv_s_d;
  logic                  rise;
  logic                  fall;
  logic                  count_inc;
  logic                  acc_inc;
  logic                  capture;
  logic [COUNT_BITS-1:0] acc;

  function automatic logic [COUNT_BITS-1:0] bump(input logic [COUNT_BITS-1:0] v);
    if (v == ALL_ONES)
      return (SATURATE != 0) ? ALL_ONES : '0;
    return v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      lv_s   <= 1'b0;
      lv_s_d <= 1'b0;
    end else begin
      sync_a <= lv_in;
      lv_s   <= sync_a;
      lv_s_d <= lv_s;
    end
  end

  assign rise = lv_s & ~lv_s_d;
  assign fall = ~lv_s & lv_s_d;

  // Reserved mode falls through to level counting; on a fall cycle lv_s is
  // already 0, so a coincident tick never reaches the accumulator.
  assign count_inc = (mode == MODE_EDGE) ? rise
                   : ((mode != MODE_WIDTH) && tick && lv_s);
  assign acc_inc   = (mode == MODE_WIDTH) && tick && lv_s;
  assign capture   = (mode == MODE_WIDTH) && fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (count_inc) begin
        count <= bump(count);
        if (count == ALL_ONES)
          ovf <= 1'b1;
      end
      if (capture) begin
        count <= acc;
        acc   <= '0;
        done  <= 1'b1;
      end else if (acc_inc) begin
        acc <= bump(acc);
        if (acc == ALL_ONES)
          ovf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/level_counter_bank.sv
`default_nettype none
// ============================================================================
// level_counter_bank : tick generator, shared mode register and N_CH channels
// Rev 1.0
// ============================================================================
module level_counter_bank
  import level_counter_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int COUNT_BITS  = DEF_COUNT_BITS,
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int TICK_HZ     = DEF_TICK_HZ,
  parameter int SATURATE    = DEF_SATURATE
) (
  input  logic                       CLK100MHZ,
  input  logic                       reset,
  input  logic [N_CH-1:0]            lv_in,
  input  logic [1:0]                 mode,
  input  logic [N_CH-1:0]            clear,
  output logic [N_CH*COUNT_BITS-1:0] hold_count,
  output logic [N_CH-1:0]            ovf,
  output logic [N_CH-1:0]            done,
  output logic                       tick
);

  // DIV must be at least 2 so that the tick counter idles at 0 out of reset.
  localparam int             DIV       = CLK_FREQ_HZ / TICK_HZ;
  localparam int             TW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);

  logic [TW-1:0] tick_cnt;
  mode_t         mode_q;
  logic          mode_chg;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset)
      tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset)
      mode_q <= MODE_LEVEL;
    else
      mode_q <= mode_t'(mode);
  end

  // Channels keep running in the registered mode; a mode switch wipes them
  // during the switch cycle so the new mode starts from a clean state.
  assign mode_chg = (mode != mode_q);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    lvc_channel #(
      .COUNT_BITS (COUNT_BITS),
      .SATURATE   (SATURATE)
    ) u_ch (
      .clk   (CLK100MHZ),
      .rst   (reset),
      .lv_in (lv_in[i]),
      .mode  (mode_q),
      .tick  (tick),
      .clear (clear[i] | mode_chg),
      .count (hold_count[i*COUNT_BITS +: COUNT_BITS]),
      .ovf   (ovf[i]),
      .done  (done[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_level_counter_bank.sv
`default_nettype none
// ============================================================================
// tb_level_counter_bank : directed checks, saturating and wrapping instances
// Rev 1.0
// ============================================================================
module tb_level_counter_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] lv_in;
  logic [1:0] mode;
  logic [1:0] clear;

  logic [7:0] hold_sat,  hold_wrap;
  logic [1:0] ovf_sat,   ovf_wrap;
  logic [1:0] done_sat,  done_wrap;
  logic       tick_sat,  tick_wrap;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clk = ~clk;

  // Edges since reset release, so tick phase is known without looking at the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  level_counter_bank #(
    .N_CH(2), .COUNT_BITS(4), .CLK_FREQ_HZ(10), .TICK_HZ(1), .SATURATE(1)
  ) u_sat (
    .CLK100MHZ (clk),
    .reset     (reset),
    .lv_in     (lv_in),
    .mode      (mode),
    .clear     (clear),
    .hold_count(hold_sat),
    .ovf       (ovf_sat),
    .done      (done_sat),
    .tick      (tick_sat)
  );

  level_counter_bank #(
    .N_CH(2), .COUNT_BITS(4), .CLK_FREQ_HZ(10), .TICK_HZ(1), .SATURATE(0)
  ) u_wrap (
    .CLK100MHZ (clk),
    .reset     (reset),
    .lv_in     (lv_in),
    .mode      (mode),
    .clear     (clear),
    .hold_count(hold_wrap),
    .ovf       (ovf_wrap),
    .done      (done_wrap),
    .tick      (tick_wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align();
    while (cyc % 10 != 0) step(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; lv_in = 2'b00; mode = 2'b00; clear = 2'b00;
    step(3);
    check("rst_hold",  hold_sat, 0);
    check("rst_ovf",   ovf_sat,  0);
    check("rst_done",  done_sat, 0);
    check("rst_tick",  tick_sat, 0);
    check("rst_hold_w", hold_wrap, 0);

    // Free-running tick: high after edges 9, 19, 29 ...
    reset = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      step(1);
      check("tick_free", tick_sat, (i % 10 == 9) ? 1 : 0);
    end
    check("idle_hold", hold_sat, 0);
    check("idle_ovf",  ovf_sat,  0);
    check("idle_done", done_sat, 0);

    // Level mode: 35-cycle high starting on a tick boundary sees 3 ticks
    align(); lv_in = 2'b01; step(35); lv_in = 2'b00; step(10);
    check("lvl_ch0",   hold_sat[3:0],  3);
    check("lvl_ch1",   hold_sat[7:4],  0);
    check("lvl_ch0_w", hold_wrap[3:0], 3);
    check("lvl_ovf",   ovf_sat, 0);

    // Edge mode: mode switch clears, then 5 pulses on ch1
    mode = 2'b01; step(1);
    check("edge_clr", hold_sat, 0);
    for (int p = 0; p < 5; p++) begin
      lv_in = 2'b10; step(3); lv_in = 2'b00; step(3);
    end
    step(4);
    check("edge_ch1", hold_sat[7:4], 5);
    check("edge_ch0", hold_sat[3:0], 0);

    // Width mode: 40-cycle pulse -> 4 ticks, captured on fall
    mode = 2'b10; step(1);
    align(); lv_in = 2'b01; step(40); lv_in = 2'b00; step(2);
    check("wid_pre_hold", hold_sat[3:0], 0);
    check("wid_pre_done", done_sat, 0);
    step(1);
    check("wid_hold", hold_sat[3:0], 4);
    check("wid_done", done_sat, 2'b01);
    step(1);
    check("wid_done_clr", done_sat, 0);
    check("wid_hold_keep", hold_sat[3:0], 4);
    // Accumulator restarted at 0 after capture
    align(); lv_in = 2'b01; step(20); lv_in = 2'b00; step(3);
    check("wid_acc_rst", hold_sat[3:0], 2);
    check("wid_done2",   done_sat, 2'b01);
    // Fall coinciding with a tick: tick ignored, 3 not 4
    align(); step(7); lv_in = 2'b01; step(30); lv_in = 2'b00; step(3);
    check("wid_fall_tick", hold_sat[3:0], 3);
    check("wid_fall_done", done_sat, 2'b01);

    // Overflow: 20 ticks into a 4-bit count
    mode = 2'b00; step(1);
    align(); lv_in = 2'b11; step(200); lv_in = 2'b00; step(10);
    check("sat_hold",  hold_sat,  8'hFF);
    check("sat_ovf",   ovf_sat,   2'b11);
    check("wrap_hold", hold_wrap, 8'h44);
    check("wrap_ovf",  ovf_wrap,  2'b11);
    clear = 2'b01; step(1); clear = 2'b00;
    check("clr_sat_hold",  hold_sat,  8'hF0);
    check("clr_sat_ovf",   ovf_sat,   2'b10);
    check("clr_wrap_hold", hold_wrap, 8'h40);
    check("clr_wrap_ovf",  ovf_wrap,  2'b10);

    // Mode change with ch0 = 7 wipes both channels
    align(); lv_in = 2'b01; step(70); lv_in = 2'b00; step(5);
    check("pre_chg_ch0", hold_sat[3:0], 7);
    mode = 2'b01; step(1);
    check("chg_hold",   hold_sat,  0);
    check("chg_ovf",    ovf_sat,   0);
    check("chg_hold_w", hold_wrap, 0);

    // Reserved mode counts like level mode
    mode = 2'b11; step(1);
    align(); lv_in = 2'b10; step(20); lv_in = 2'b00; step(5);
    check("rsvd_ch1", hold_sat[7:4], 2);

    // Asynchronous reset mid-count, then tick restart
    mode = 2'b00; step(1);
    align(); lv_in = 2'b01; step(25);
    check("pre_rst_ch0", hold_sat[3:0], 2);
    #2 reset = 1'b1;
    #1;
    check("async_hold", hold_sat, 0);
    check("async_ovf",  ovf_sat,  0);
    check("async_tick", tick_sat, 0);
    lv_in = 2'b00; step(2); reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check("tick_restart", tick_sat, (i == 9) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/level_counter_bank.md
LEVEL_COUNTER_BANK -- requirements
Module: level_counter_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent input channels.
REQ-002 SHALL have parameter COUNT_BITS, default 8, width of each channel count.
REQ-003 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, input clock frequency.
REQ-004 SHALL have parameter TICK_HZ, default 2, count tick rate; DIV = CLK_FREQ_HZ/TICK_HZ, DIV >= 2.
REQ-005 SHALL have parameter SATURATE, default 1; 1 = saturate at max, 0 = wrap.
REQ-006 SHALL have port CLK100MHZ  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port lv_in  in  N_CH  asynchronous level inputs, one bit per channel.
REQ-009 SHALL have port mode  in  2  count mode, shared by all channels (mode_t).
REQ-010 SHALL have port clear  in  N_CH  synchronous per-channel clear.
REQ-011 SHALL have port hold_count  out  N_CH*COUNT_BITS  channel i occupies bits [i*COUNT_BITS +: COUNT_BITS].
REQ-012 SHALL have port ovf  out  N_CH  sticky overflow flag per channel.
REQ-013 SHALL have port done  out  N_CH  one-cycle capture pulse (MODE_WIDTH only).
REQ-014 SHALL have port tick  out  1  one-cycle tick strobe.

Function
REQ-015 Tick: free-running counter 0..DIV-1, width $clog2(DIV); tick=1 for exactly the cycle the counter equals DIV-1, then it wraps to 0. No derived clocks.
REQ-016 Each lv_in bit SHALL pass a 2-flop synchroniser (lv_s); rise = lv_s & ~lv_s_d, fall = ~lv_s & lv_s_d.
REQ-017 MODE_LEVEL (2'b00): on tick with lv_s=1, count +1; otherwise hold.
REQ-018 MODE_EDGE (2'b01): on rise, count +1, independent of tick.
REQ-019 MODE_WIDTH (2'b10): internal acc +1 on tick with lv_s=1; on fall, hold_count <= acc, acc <= 0, done=1 for one cycle; hold_count unchanged otherwise.
REQ-020 Mode 2'b11 SHALL behave as MODE_LEVEL.
REQ-021 Overflow: increment from all-ones -> SATURATE=1 holds all-ones, SATURATE=0 wraps to 0; both set ovf (sticky). Same rule for acc.
REQ-022 Priority per channel, per cycle: mode change > clear > capture/increment.
REQ-023 clear[i]=1 -> count, acc, ovf of channel i become 0 next edge; done[i]=0 that cycle.
REQ-024 Registered mode_q; mode != mode_q -> all channels cleared as REQ-023 in that cycle; new mode applies from the next cycle.
REQ-025 Fall and tick in the same cycle (MODE_WIDTH): tick ignored (lv_s=0); captured value = acc before that edge.
REQ-026 Input/count latency: lv_in change visible in lv_s after 2 edges; count updates 1 edge after the qualifying event.

Reset
REQ-027 reset=1 SHALL asynchronously force: tick counter, tick, sync flops, mode_q(=2'b00), acc, hold_count, ovf, done all to 0.
REQ-028 Reset deassertion mid-operation SHALL restart the tick counter at 0; first tick occurs DIV cycles later.

Structure
REQ-029 Package level_counter_pkg SHALL hold typedef enum logic[1:0] mode_t {MODE_LEVEL, MODE_EDGE, MODE_WIDTH, MODE_RSVD} and default parameter constants.
REQ-030 Sub-module lvc_channel (sync, edge detect, acc, count, ovf, done) SHALL be instantiated N_CH times via generate; tick generator and mode_q live in the top.

Verification (CLK_FREQ_HZ=10, TICK_HZ=1 -> DIV=10, N_CH=2, COUNT_BITS=4)
REQ-031 reset release, lv_in=0, 50 cycles -> tick pulses at cycles 10,20,...; all counts 0, ovf=0, done=0.
REQ-032 MODE_LEVEL, lv_in[0]=1 for 35 cycles from sync -> ch0=3, ch1=0.
REQ-033 MODE_EDGE, 5 pulses of 3 cycles on lv_in[1] -> ch1=5 regardless of tick timing.
REQ-034 MODE_WIDTH, lv_in[0] high for 40 cycles -> on fall ch0=4, done[0] one cycle, acc back to 0.
REQ-035 MODE_LEVEL, lv_in held high 200 cycles: SATURATE=1 -> 15, ovf=1; SATURATE=0 -> 20 mod 16=4, ovf=1; clear[0] -> 0, ovf=0.
REQ-036 Mode change 00->01 with ch0=7 -> both channels 0 next edge; async reset mid-count -> outputs 0 without a clock edge.
